cordic_engine: RTL and testbench
================================

Name: cordic_engine

Overview:
- Parametrised, iterative CORDIC engine: one micro-rotation per clock, start/busy/done handshake.
- Two modes:
  - Rotation: cos and sin of an angle.
  - Vectoring: scaled magnitude and atan(y/x) of a vector.
- Successor to the fixed 22-bit, cos-only unrolled CORDIC. Adds width/iteration parameters, sin output, vectoring mode, arithmetic shifts and reset priority.
- Sits between the FP unpack stage and the trig/atan result formatter.

Parameters:
- WIDTH, 22: data and angle word width. Signed two's complement, legal 12..32.
- FRAC, WIDTH-2: fractional bits. All words are Q2.FRAC (range [-2,2)). Must be ≤30.
- ITERATIONS, 16: number of micro-rotations, legal 4..FRAC.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  request; accepted when high and busy=0
- mode  in  1  0=rotation, 1=vectoring; sampled on accepted start
- angle  in  WIDTH  rotation angle in radians, Q2.FRAC, legal |angle| ≤ pi/2; ignored in vectoring
- x_in  in  WIDTH  vectoring x, must be ≥0; ignored in rotation
- y_in  in  WIDTH  vectoring y; ignored in rotation
- busy  out  1  iterations in progress
- done  out  1  one-cycle pulse; results valid
- cos_out  out  WIDTH  rotation: cos(angle); vectoring: An·sqrt(x²+y²), An≈1.646760
- sin_out  out  WIDTH  rotation: sin(angle); vectoring: residual y (≈0)
- z_out  out  WIDTH  rotation: residual angle (≈0); vectoring: atan(y_in/x_in)

Behaviour:
- Reset (reset=0 at clk edge):
  - busy=0, done=0, cos_out=sin_out=z_out=0, iteration counter=0.
  - Reset dominates start and aborts any operation in flight; no done is produced for the aborted request.
- Accept: at an edge with reset=1, start=1, busy=0:
  - Load the registers:
    - Rotation: x=K, y=0, z=angle.
    - Vectoring: x=x_in, y=y_in, z=0.
  - K = round(0.6072529350·2^FRAC).
  - Latch mode; busy=1 from the next cycle; counter i=0.
- start while busy=1 is ignored (no queueing); it does not affect the operation in flight.
- Iterate: each cycle with busy=1 performs iteration i, then i increments.
  - Direction d:
    - Rotation: d=1 if z<0.
    - Vectoring: d=1 if y<0 (y=0 counts as positive).
  - d=0: x'=x+(y>>>i), y'=y-(x>>>i), z'=z+e_i.
  - d=1: x'=x-(y>>>i), y'=y+(x>>>i), z'=z-e_i.
  - In rotation mode the d=0 case drives z down, so the z sign convention is inverted relative to the above. The rotation-mode update is:
    - d=0: x'=x-(y>>>i), y'=y+(x>>>i), z'=z-e_i.
    - d=1: x'=x+(y>>>i), y'=y-(x>>>i), z'=z+e_i.
  - >>> is arithmetic (sign-preserving).
- Angle table: e_i = round(atan(2^-i)·2^30), a constant table of 32 entries, applied as (e_i >>> (30-FRAC)) with round-half-up.
- Internal x/y/z are WIDTH+2 bits, sign-extended on load.
- Outputs are the low WIDTH bits of the internal values. No saturation: out-of-range results wrap.
  - Vectoring callers must keep sqrt(x²+y²) < 1.21 for the result to stay in range.
- Finish: after the iteration with i=ITERATIONS-1:
  - busy=0 and done=1 for exactly one cycle.
  - cos_out/sin_out/z_out update in the same edge that raises done.
- Latency: done is high ITERATIONS+1 cycles after the start edge. Throughput is one result per ITERATIONS+1 cycles.
- Output hold: outputs hold their value until the next finish or reset. They do not change on accept.
- Back-to-back: start may be high in the done cycle (busy=0) and is accepted.

Test Plan:
Defaults WIDTH=22, FRAC=20, ITERATIONS=16; tolerance ±64 LSB.
- Rotation, angle=0 -> after 17 cycles: done pulse; cos_out≈1048576, sin_out≈0, z_out≈0.
- Rotation, angle=823550 (pi/4) -> cos_out≈741455, sin_out≈741455. Angle=-1098066 (-pi/3) -> cos_out≈524288, sin_out≈-908093.
- Vectoring, x_in=y_in=524288 -> z_out≈823550, cos_out≈1220996, sin_out≈0. x_in=524288, y_in=-524288 -> z_out≈-823550.
- start held high continuously -> done exactly every 17 cycles. A second start pulse at cycle 5 of an operation is ignored; outputs stay unchanged until done.
- reset=0 at cycle 8 of an operation -> next cycle busy=0, done=0, outputs=0. No done ever appears for the aborted request. start with reset=0 is not accepted.
- Sweep of 64 random legal angles, ITERATIONS=12 and WIDTH=16/FRAC=14 builds -> matches a real-number model within ±2^-(ITERATIONS-4) scaled. done latency = ITERATIONS+1.

Source files
------------

// File: rtl/cordic_engine_if.sv
// ---------------------------------------------------------------------------
// cordic_engine_if : start/busy/done request and result bundle for cordic_engine
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cordic_engine_if #(
   parameter int WIDTH = 22
);
   logic                    start;
   logic                    mode;
   logic signed [WIDTH-1:0] angle;
   logic signed [WIDTH-1:0] x_in;
   logic signed [WIDTH-1:0] y_in;
   logic                    busy;
   logic                    done;
   logic signed [WIDTH-1:0] cos_out;
   logic signed [WIDTH-1:0] sin_out;
   logic signed [WIDTH-1:0] z_out;

   modport master (
      output start, mode, angle, x_in, y_in,
      input  busy, done, cos_out, sin_out, z_out
   );

   modport slave (
      input  start, mode, angle, x_in, y_in,
      output busy, done, cos_out, sin_out, z_out
   );
endinterface

`default_nettype wire

// File: rtl/cordic_engine.sv
// ---------------------------------------------------------------------------
// cordic_engine : iterative rotation/vectoring CORDIC, one micro-rotation per clock
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cordic_engine #(
   parameter int WIDTH      = 22,
   parameter int FRAC       = WIDTH - 2,
   parameter int ITERATIONS = 16
) (
   input  wire logic      clk,
   input  wire logic      reset,
   cordic_engine_if.slave bus
);

   localparam int c_IW   = WIDTH + 2;
   localparam int c_SH   = 30 - FRAC;
   localparam int c_HSH  = (c_SH > 0) ? c_SH - 1 : 0;
   localparam logic signed [33:0] c_HALF = (c_SH > 0) ? (34'sd1 <<< c_HSH) : 34'sd0;
   localparam logic signed [33:0] c_K30  = 34'sd652032874;
   localparam logic signed [33:0] c_K    = (c_K30 + c_HALF) >>> c_SH;
   localparam logic [4:0]         c_LAST = 5'(ITERATIONS - 1);

   generate
      if (WIDTH < 12 || WIDTH > 32 || FRAC > 30 || FRAC >= WIDTH ||
          ITERATIONS < 4 || ITERATIONS > FRAC) begin : g_param_check
         $error("cordic_engine: illegal WIDTH/FRAC/ITERATIONS combination");
      end
   endgenerate

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // atan(2^-i) scaled by 2^30, rounded to nearest
   function automatic logic signed [33:0] atan_q30(input logic [4:0] idx);
      logic signed [33:0] v;
      case (idx)
         5'd0:    v = 34'sd843314857;
         5'd1:    v = 34'sd497837829;
         5'd2:    v = 34'sd263043837;
         5'd3:    v = 34'sd133525159;
         5'd4:    v = 34'sd67021687;
         5'd5:    v = 34'sd33543516;
         5'd6:    v = 34'sd16775851;
         5'd7:    v = 34'sd8388437;
         5'd8:    v = 34'sd4194283;
         5'd9:    v = 34'sd2097149;
         5'd10:   v = 34'sd1048576;
         5'd11:   v = 34'sd524288;
         5'd12:   v = 34'sd262144;
         5'd13:   v = 34'sd131072;
         5'd14:   v = 34'sd65536;
         5'd15:   v = 34'sd32768;
         5'd16:   v = 34'sd16384;
         5'd17:   v = 34'sd8192;
         5'd18:   v = 34'sd4096;
         5'd19:   v = 34'sd2048;
         5'd20:   v = 34'sd1024;
         5'd21:   v = 34'sd512;
         5'd22:   v = 34'sd256;
         5'd23:   v = 34'sd128;
         5'd24:   v = 34'sd64;
         5'd25:   v = 34'sd32;
         5'd26:   v = 34'sd16;
         5'd27:   v = 34'sd8;
         5'd28:   v = 34'sd4;
         5'd29:   v = 34'sd2;
         5'd30:   v = 34'sd1;
         default: v = 34'sd0;
      endcase
      return v;
   endfunction

   function automatic logic signed [c_IW-1:0] atan_step(input logic [4:0] idx);
      logic signed [33:0] e;
      e = (atan_q30(idx) + c_HALF) >>> c_SH;
      return e[c_IW-1:0];
   endfunction

   state_t                  r_state;
   state_t                  w_next;
   logic                    w_accept;
   logic                    w_last;
   logic                    r_mode;
   logic                    r_done;
   logic [4:0]              r_iter;
   logic signed [c_IW-1:0]  r_x;
   logic signed [c_IW-1:0]  r_y;
   logic signed [c_IW-1:0]  r_z;
   logic signed [WIDTH-1:0] r_cos;
   logic signed [WIDTH-1:0] r_sin;
   logic signed [WIDTH-1:0] r_zo;

   logic signed [c_IW-1:0]  w_xs;
   logic signed [c_IW-1:0]  w_ys;
   logic signed [c_IW-1:0]  w_e;
   logic                    w_ccw;
   logic signed [c_IW-1:0]  w_x_nx;
   logic signed [c_IW-1:0]  w_y_nx;
   logic signed [c_IW-1:0]  w_z_nx;

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_last   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept = 1'b1;
               w_next   = S_RUN;
            end
         end
         S_RUN: begin
            if (r_iter == c_LAST) begin
               w_last = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // w_ccw selects the x-ys / y+xs / z-e branch: rotation drives z toward 0,
   // vectoring drives y toward 0 (y=0 counts as positive)
   always_comb begin
      w_xs   = r_x >>> r_iter;
      w_ys   = r_y >>> r_iter;
      w_e    = atan_step(r_iter);
      w_ccw  = r_mode ? r_y[c_IW-1] : ~r_z[c_IW-1];
      w_x_nx = r_x + w_ys;
      w_y_nx = r_y - w_xs;
      w_z_nx = r_z + w_e;
      if (w_ccw) begin
         w_x_nx = r_x - w_ys;
         w_y_nx = r_y + w_xs;
         w_z_nx = r_z - w_e;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
         r_mode  <= 1'b0;
         r_iter  <= 5'd0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_cos   <= '0;
         r_sin   <= '0;
         r_zo    <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= w_last;
         if (w_accept) begin
            r_mode <= bus.mode;
            r_iter <= 5'd0;
            if (bus.mode) begin
               r_x <= {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
               r_y <= {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
               r_z <= '0;
            end else begin
               r_x <= c_K[c_IW-1:0];
               r_y <= '0;
               r_z <= {{2{bus.angle[WIDTH-1]}}, bus.angle};
            end
         end else if (r_state == S_RUN) begin
            r_x    <= w_x_nx;
            r_y    <= w_y_nx;
            r_z    <= w_z_nx;
            r_iter <= w_last ? 5'd0 : r_iter + 5'd1;
            if (w_last) begin
               r_cos <= w_x_nx[WIDTH-1:0];
               r_sin <= w_y_nx[WIDTH-1:0];
               r_zo  <= w_z_nx[WIDTH-1:0];
            end
         end
      end
   end

   assign bus.busy    = (r_state == S_RUN);
   assign bus.done    = r_done;
   assign bus.cos_out = r_cos;
   assign bus.sin_out = r_sin;
   assign bus.z_out   = r_zo;

endmodule

`default_nettype wire

// File: tb/tb_cordic_engine.sv
// ---------------------------------------------------------------------------
// tb_cordic_engine : random and directed checks of cordic_engine against a real-number model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cordic_engine;
   parameter int WIDTH      = 22;
   parameter int FRAC       = WIDTH - 2;
   parameter int ITERATIONS = 16;
   parameter int TOL        = 64;

   localparam real c_PI = 3.14159265358979323846;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   real  scale;
   longint exp_c, exp_s, exp_z;

   cordic_engine_if #(.WIDTH(WIDTH)) bus ();

   cordic_engine #(
      .WIDTH      (WIDTH),
      .FRAC       (FRAC),
      .ITERATIONS (ITERATIONS)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input longint obs, input longint expv, input longint tol);
      n_checks++;
      if ((obs - expv) > tol || (expv - obs) > tol) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, expv, tol);
      end
   endtask

   function automatic real gain();
      real g = 1.0;
      for (int i = 0; i < ITERATIONS; i++) g = g * $sqrt(1.0 + 2.0 ** (-2.0 * i));
      return g;
   endfunction

   // Ideal mathematical result of the requested operation
   task automatic model(input bit m, input int a, input int xi, input int yi);
      real ar, xr, yr;
      if (!m) begin
         ar    = a / scale;
         exp_c = longint'($cos(ar) * scale);
         exp_s = longint'($sin(ar) * scale);
         exp_z = 0;
      end else begin
         xr    = xi / scale;
         yr    = yi / scale;
         exp_c = longint'(gain() * $sqrt(xr * xr + yr * yr) * scale);
         exp_s = 0;
         exp_z = longint'($atan2(yr, xr) * scale);
      end
   endtask

   task automatic drive(input bit m, input int a, input int xi, input int yi);
      bus.mode  = m;
      bus.angle = a[WIDTH-1:0];
      bus.x_in  = xi[WIDTH-1:0];
      bus.y_in  = yi[WIDTH-1:0];
   endtask

   task automatic run_op(input bit m, input int a, input int xi, input int yi, output int lat);
      @(negedge clk);
      drive(m, a, xi, yi);
      bus.start = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         bus.start = 1'b0;
      end while (!bus.done && lat < 4 * ITERATIONS + 10);
   endtask

   task automatic op_check(input string tag, input bit m, input int a, input int xi, input int yi);
      int lat;
      run_op(m, a, xi, yi, lat);
      model(m, a, xi, yi);
      check({tag, " latency"}, lat, ITERATIONS + 1, 0);
      check({tag, " cos"}, longint'(bus.cos_out), exp_c, TOL);
      check({tag, " sin"}, longint'(bus.sin_out), exp_s, TOL);
      check({tag, " z"},   longint'(bus.z_out),   exp_z, TOL);
   endtask

   function automatic int fix(input real r);
      return int'(r * scale);
   endfunction

   function automatic real urand(input real lo, input real hi);
      return lo + (hi - lo) * (real'($urandom_range(0, 1000000)) / 1000000.0);
   endfunction

   initial begin
      int lat, cyc, nbad, ndone, nbusy;
      int dq[$];
      longint pc, ps, pz;

      n_checks  = 0;
      n_errors  = 0;
      scale     = 2.0 ** FRAC;
      reset     = 1'b0;
      bus.start = 1'b0;
      drive(1'b0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("reset busy", bus.busy, 0, 0);
      check("reset done", bus.done, 0, 0);
      check("reset cos",  bus.cos_out, 0, 0);
      check("reset sin",  bus.sin_out, 0, 0);
      check("reset z",    bus.z_out, 0, 0);
      reset = 1'b1;

      op_check("rot 0",     1'b0, 0, 0, 0);
      op_check("rot pi/4",  1'b0, fix(c_PI / 4.0), 0, 0);
      op_check("rot -pi/3", 1'b0, fix(-c_PI / 3.0), 0, 0);
      op_check("vec 45",    1'b1, 0, fix(0.5), fix(0.5));
      op_check("vec -45",   1'b1, 0, fix(0.5), fix(-0.5));

      for (int i = 0; i < 64; i++)
         op_check("rand rot", 1'b0, fix(urand(-c_PI / 2.0, c_PI / 2.0)), 0, 0);
      for (int i = 0; i < 32; i++)
         op_check("rand vec", 1'b1, 0, fix(urand(0.1, 0.8)), fix(urand(-0.8, 0.8)));

      // Second start mid-operation must neither disturb the held outputs nor queue
      pc = exp_c; ps = exp_s; pz = exp_z;
      @(negedge clk);
      drive(1'b0, fix(0.6), 0, 0);
      bus.start = 1'b1;
      lat  = 0;
      nbad = 0;
      do begin
         @(negedge clk);
         lat++;
         bus.start = (lat == 5);
         if (lat == 5) drive(1'b0, fix(-1.2), 0, 0);
         if (!bus.done) begin
            if (longint'(bus.cos_out) > pc + TOL || longint'(bus.cos_out) < pc - TOL ||
                longint'(bus.sin_out) > ps + TOL || longint'(bus.sin_out) < ps - TOL ||
                longint'(bus.z_out)   > pz + TOL || longint'(bus.z_out)   < pz - TOL)
               nbad++;
         end
      end while (!bus.done && lat < 4 * ITERATIONS + 10);
      bus.start = 1'b0;
      model(1'b0, fix(0.6), 0, 0);
      check("ignore hold", nbad, 0, 0);
      check("ignore latency", lat, ITERATIONS + 1, 0);
      check("ignore cos", longint'(bus.cos_out), exp_c, TOL);
      check("ignore sin", longint'(bus.sin_out), exp_s, TOL);
      ndone = 0;
      repeat (2 * ITERATIONS) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check("ignore no queue", ndone, 0, 0);

      // start held high: one result every ITERATIONS+1 cycles
      @(negedge clk);
      drive(1'b0, fix(1.0), 0, 0);
      bus.start = 1'b1;
      for (cyc = 1; cyc <= 3 * (ITERATIONS + 1) + 5; cyc++) begin
         @(negedge clk);
         if (bus.done) dq.push_back(cyc);
      end
      bus.start = 1'b0;
      model(1'b0, fix(1.0), 0, 0);
      check("stream cos", longint'(bus.cos_out), exp_c, TOL);
      check("stream count", dq.size(), 3, 0);
      if (dq.size() == 3) begin
         check("stream first", dq[0], ITERATIONS + 1, 0);
         check("stream gap1", dq[1] - dq[0], ITERATIONS + 1, 0);
         check("stream gap2", dq[2] - dq[1], ITERATIONS + 1, 0);
      end
      lat = 0;
      while (bus.busy && lat < 4 * ITERATIONS) begin
         @(negedge clk);
         lat++;
      end
      check("stream drain busy", bus.busy, 0, 0);

      // Abort by reset at cycle 8, start held during reset
      @(negedge clk);
      drive(1'b0, fix(0.3), 0, 0);
      bus.start = 1'b1;
      repeat (8) @(negedge clk);
      bus.start = 1'b1;
      reset = 1'b0;
      @(negedge clk);
      check("abort busy", bus.busy, 0, 0);
      check("abort done", bus.done, 0, 0);
      check("abort cos",  bus.cos_out, 0, 0);
      check("abort sin",  bus.sin_out, 0, 0);
      check("abort z",    bus.z_out, 0, 0);
      nbusy = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.busy) nbusy++;
      end
      check("start in reset", nbusy, 0, 0);
      reset     = 1'b1;
      bus.start = 1'b0;
      ndone = 0;
      nbusy = 0;
      repeat (2 * ITERATIONS + 5) begin
         @(negedge clk);
         if (bus.done) ndone++;
         if (bus.busy) nbusy++;
      end
      check("abort no done", ndone, 0, 0);
      check("abort no busy", nbusy, 0, 0);

      op_check("post reset", 1'b0, fix(-0.9), 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
